// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the uart_tx channel arbiter and its producers.
// State encodings, byte width and line-ending characters.
package uart_tx_arbiter_pkg;

    localparam int BYTE_W = 8;

    localparam logic [BYTE_W-1:0] CHAR_CR = 8'h0D;
    localparam logic [BYTE_W-1:0] CHAR_LF = 8'h0A;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or after ptr_i.
// Produces the winner one-hot, its index and an any-request flag.
module uart_tx_arbiter_rr_pick #(
    parameter int N  = 3,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  onehot_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    int j;

    // Walk from farthest to nearest so the nearest request wins last.
    always_comb begin
        onehot_o = '0;
        idx_o    = '0;
        any_o    = |req_i;
        j        = 0;
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(ptr_i) + k;
            if (j >= N) j = j - N;
            if (req_i[j]) begin
                onehot_o    = '0;
                onehot_o[j] = 1'b1;
                idx_o       = IW'(j);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one uart_tx byte channel.
// Holds the grant until a last byte, with a mid-packet stall watchdog.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter  int NUM_REQ       = 3,
    parameter  int STALL_TIMEOUT = 2700000,
    localparam int IDX_W         = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ*BYTE_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [BYTE_W-1:0]         tx_data,
    output logic                      tx_data_valid,
    input  logic                      tx_data_ready,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      busy,
    output logic                      stall_abort,
    output logic [IDX_W-1:0]          stall_id
);

    localparam int CW = (STALL_TIMEOUT > 0) ? $clog2(STALL_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST =
        CW'((STALL_TIMEOUT > 0) ? STALL_TIMEOUT - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_REQ - 1);

    arb_state_e          state_q, state_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]    stall_id_q, stall_id_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                abort_q, abort_d;
    logic [BYTE_W-1:0]   data_q, data_d;
    logic                valid_q, valid_d;

    logic [NUM_REQ-1:0]  pick_oh;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_any;
    logic                out_free;
    logic                xfer;
    logic                accept;
    logic                owner_valid;
    logic                owner_last;
    logic [IDX_W-1:0]    next_ptr;

    uart_tx_arbiter_rr_pick #(
        .N  (NUM_REQ),
        .IW (IDX_W)
    ) u_pick (
        .req_i    (req_valid),
        .ptr_i    (rr_ptr_q),
        .onehot_o (pick_oh),
        .idx_o    (pick_idx),
        .any_o    (pick_any)
    );

    assign out_free    = !valid_q || tx_data_ready;
    assign xfer        = (state_q == ST_XFER);
    assign req_ready   = (xfer && out_free) ? grant_q : '0;
    assign accept      = |(req_valid & req_ready);
    assign owner_valid = req_valid[owner_q];
    assign owner_last  = req_last[owner_q];
    assign next_ptr    = (owner_q == IDX_MAX) ? '0 : owner_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        cnt_d      = cnt_q;
        abort_d    = 1'b0;
        stall_id_d = stall_id_q;
        data_d     = data_q;
        valid_d    = valid_q;

        if (accept) begin
            data_d  = req_data[{owner_q, 3'b000} +: BYTE_W];
            valid_d = 1'b1;
        end else if (valid_q && tx_data_ready) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    grant_d = pick_oh;
                    owner_d = pick_idx;
                    cnt_d   = '0;
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                if (accept) begin
                    cnt_d = '0;
                    if (owner_last) begin
                        grant_d  = '0;
                        rr_ptr_d = next_ptr;
                        state_d  = ST_IDLE;
                    end
                end else if (STALL_TIMEOUT > 0 && !owner_valid) begin
                    // Backpressure with valid held high never counts.
                    if (cnt_q == CNT_LAST) begin
                        grant_d    = '0;
                        rr_ptr_d   = next_ptr;
                        abort_d    = 1'b1;
                        stall_id_d = owner_q;
                        state_d    = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            cnt_q      <= '0;
            abort_q    <= 1'b0;
            stall_id_q <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            cnt_q      <= cnt_d;
            abort_q    <= abort_d;
            stall_id_q <= stall_id_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
        end
    end

    assign grant         = grant_q;
    assign tx_data       = data_q;
    assign tx_data_valid = valid_q;
    assign busy          = xfer || valid_q;
    assign stall_abort   = abort_q;
    assign stall_id      = stall_id_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed steps plus randomized packet traffic.
// Wire order is predicted from packet queues and a plain round-robin walk.
module tb_uart_tx_arbiter;

    localparam int NR = 3;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NR*8-1:0] req_data;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_last;
    logic [NR-1:0]   req_ready;
    logic [7:0]      tx_data;
    logic            tx_data_valid;
    logic            tx_data_ready;
    logic [NR-1:0]   grant;
    logic            busy;
    logic            stall_abort;
    logic [1:0]      stall_id;

    int tests = 0;
    int fails = 0;
    int ptr;
    int n;
    int acc;

    byte unsigned pk_dat [NR][4][6];
    int           pk_len [NR][4];
    int           pk_n   [NR];

    uart_tx_arbiter #(
        .NUM_REQ       (NR),
        .STALL_TIMEOUT (TO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_data      (req_data),
        .req_valid     (req_valid),
        .req_last      (req_last),
        .req_ready     (req_ready),
        .tx_data       (tx_data),
        .tx_data_valid (tx_data_valid),
        .tx_data_ready (tx_data_ready),
        .grant         (grant),
        .busy          (busy),
        .stall_abort   (stall_abort),
        .stall_id      (stall_id)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL global_timeout observed=hang expected=finish");
        $fatal(1, "bench timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_src(input int s, input logic v,
                           input logic [7:0] d, input logic l);
        req_valid[s]        = v;
        req_data[8*s +: 8]  = d;
        req_last[s]         = l;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n         = 1'b0;
        req_valid     = '0;
        req_last      = '0;
        tx_data_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic clear_pkts();
        for (int i = 0; i < NR; i++) pk_n[i] = 0;
    endtask

    task automatic add_pkt(input int s, input int len, input bit rnd);
        int p;
        p = pk_n[s];
        pk_len[s][p] = len;
        for (int b = 0; b < len; b++)
            pk_dat[s][p][b] = rnd ? 8'($urandom) : 8'(s * 64 + p * 16 + b);
        pk_n[s] = p + 1;
    endtask

    task automatic run_pkts(input string tag, input int ptr0,
                            input int rdy_pct, input int gap_pct,
                            input bit chk_gap, output int ptr_end);
        byte unsigned exp_q[$];
        byte unsigned wire_q[$];
        int acc_cyc[$];
        bit acc_last[$];
        int nxt[NR];
        int pi[NR];
        int bi[NR];
        int p;
        int j;
        int left;
        int cyc;
        logic [31:0] got;

        p    = ptr0;
        left = 0;
        for (int i = 0; i < NR; i++) begin
            nxt[i] = 0;
            pi[i]  = 0;
            bi[i]  = 0;
            left  += pk_n[i];
        end
        while (left > 0) begin
            j = p;
            while (nxt[j] >= pk_n[j]) j = (j + 1) % NR;
            for (int b = 0; b < pk_len[j][nxt[j]]; b++)
                exp_q.push_back(pk_dat[j][nxt[j]][b]);
            nxt[j]++;
            left--;
            p = (j + 1) % NR;
        end
        ptr_end = p;

        cyc = 0;
        while (wire_q.size() < exp_q.size() && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < NR; i++) begin
                if (pi[i] >= pk_n[i]) begin
                    req_valid[i] = 1'b0;
                    req_last[i]  = 1'b0;
                end else begin
                    req_data[8*i +: 8] = pk_dat[i][pi[i]][bi[i]];
                    req_last[i]  = (bi[i] == pk_len[i][pi[i]] - 1);
                    req_valid[i] = (bi[i] == 0) ||
                                   ($urandom_range(99) >= gap_pct);
                end
            end
            tx_data_ready = ($urandom_range(99) < rdy_pct);
            #1;
            chk({tag, "_ready_owner"}, 32'(req_ready & ~grant), 32'd0);
            if (tx_data_valid && tx_data_ready) wire_q.push_back(tx_data);
            for (int i = 0; i < NR; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    acc_cyc.push_back(cyc);
                    acc_last.push_back(req_last[i]);
                    bi[i]++;
                    if (bi[i] == pk_len[i][pi[i]]) begin
                        bi[i] = 0;
                        pi[i]++;
                    end
                end
            end
        end
        req_valid     = '0;
        req_last      = '0;
        tx_data_ready = 1'b1;

        chk({tag, "_count"}, wire_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size(); k++) begin
            got = (k < wire_q.size()) ? 32'(wire_q[k]) : 32'hDEAD_BEEF;
            chk({tag, "_byte"}, got, 32'(exp_q[k]));
        end
        if (chk_gap)
            for (int k = 0; k + 1 < acc_cyc.size(); k++)
                if (acc_last[k])
                    chk({tag, "_bubble"}, acc_cyc[k+1] - acc_cyc[k], 2);
        repeat (3) @(negedge clk);
        #1;
        chk({tag, "_idle_busy"}, busy, 1'b0);
        chk({tag, "_idle_grant"}, grant, 3'b000);
    endtask

    initial begin
        req_valid     = '0;
        req_last      = '0;
        req_data      = '0;
        tx_data_ready = 1'b1;
        rst_n         = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_grant", grant, 3'b000);
        chk("rst_valid", tx_data_valid, 1'b0);
        chk("rst_data", tx_data, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_abort", stall_abort, 1'b0);
        chk("rst_id", stall_id, 2'd0);
        chk("rst_ready", req_ready, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;

        // Single source "AB": grant, latency and release
        @(negedge clk);
        set_src(0, 1'b1, 8'h41, 1'b0);
        #1 chk("t1_ready_idle", req_ready, 3'b000);
        @(negedge clk);
        #1;
        chk("t1_grant", grant, 3'b001);
        chk("t1_ready", req_ready, 3'b001);
        chk("t1_valid0", tx_data_valid, 1'b0);
        @(negedge clk);
        set_src(0, 1'b1, 8'h42, 1'b1);
        #1;
        chk("t1_dataA", tx_data, 8'h41);
        chk("t1_validA", tx_data_valid, 1'b1);
        @(negedge clk);
        set_src(0, 1'b0, 8'h00, 1'b0);
        #1;
        chk("t1_dataB", tx_data, 8'h42);
        chk("t1_release", grant, 3'b000);
        @(negedge clk);
        #1;
        chk("t1_drain", tx_data_valid, 1'b0);
        chk("t1_busy", busy, 1'b0);

        // rr_ptr now 1: three single-byte packets go 1,2,0
        clear_pkts();
        for (int s = 0; s < NR; s++) add_pkt(s, 1, 1'b0);
        run_pkts("t1_rr", 1, 100, 0, 1'b0, ptr);

        // All three with 2-byte packets from rr_ptr 0
        do_reset();
        clear_pkts();
        for (int s = 0; s < NR; s++) add_pkt(s, 2, 1'b0);
        run_pkts("t2", 0, 100, 0, 1'b1, ptr);

        // Backpressure while holding 0x55
        @(negedge clk);
        set_src(0, 1'b1, 8'h55, 1'b0);
        tx_data_ready = 1'b0;
        @(negedge clk);
        #1 chk("t3_ready_empty", req_ready, 3'b001);
        @(negedge clk);
        set_src(0, 1'b1, 8'h66, 1'b1);
        #1;
        chk("t3_hold_data", tx_data, 8'h55);
        chk("t3_hold_ready", req_ready, 3'b000);
        repeat (9) begin
            @(negedge clk);
            #1;
            chk("t3_stable_data", tx_data, 8'h55);
            chk("t3_stable_valid", tx_data_valid, 1'b1);
            chk("t3_stable_ready", req_ready, 3'b000);
        end
        @(negedge clk);
        tx_data_ready = 1'b1;
        #1 chk("t3_ready_rise", req_ready, 3'b001);
        @(negedge clk);
        set_src(0, 1'b0, 8'h00, 1'b0);
        #1;
        chk("t3_next_data", tx_data, 8'h66);
        chk("t3_next_valid", tx_data_valid, 1'b1);
        chk("t3_release", grant, 3'b000);
        @(negedge clk);
        #1 chk("t3_drain", tx_data_valid, 1'b0);

        // Watchdog: req1 stalls mid-packet, req2 waits
        @(negedge clk);
        set_src(1, 1'b1, 8'h77, 1'b0);
        set_src(2, 1'b1, 8'h88, 1'b1);
        @(negedge clk);
        #1;
        chk("t4_grant", grant, 3'b010);
        chk("t4_ready", req_ready, 3'b010);
        @(negedge clk);
        set_src(1, 1'b0, 8'h77, 1'b0);
        #1;
        chk("t4_data", tx_data, 8'h77);
        chk("t4_nonowner", req_ready[2], 1'b0);
        n = 1;
        while (!stall_abort && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("t4_abort_delay", n - 1, TO);
        chk("t4_abort", stall_abort, 1'b1);
        chk("t4_id", stall_id, 2'd1);
        chk("t4_grant_clr", grant, 3'b000);
        @(negedge clk);
        #1;
        chk("t4_next_grant", grant, 3'b100);
        chk("t4_pulse", stall_abort, 1'b0);
        chk("t4_id_held", stall_id, 2'd1);
        @(negedge clk);
        set_src(2, 1'b0, 8'h00, 1'b0);
        #1;
        chk("t4_req2_data", tx_data, 8'h88);
        chk("t4_req2_rel", grant, 3'b000);
        repeat (2) @(negedge clk);

        // Reach rr_ptr 2, then req2 and req0 together
        clear_pkts();
        add_pkt(1, 1, 1'b0);
        run_pkts("t5_pre", 0, 100, 0, 1'b0, ptr);
        clear_pkts();
        add_pkt(2, 1, 1'b0);
        add_pkt(0, 1, 1'b0);
        run_pkts("t5", 2, 100, 0, 1'b0, ptr);
        chk("t5_ptr_model", ptr, 1);
        clear_pkts();
        for (int s = 0; s < NR; s++) add_pkt(s, 1, 1'b0);
        run_pkts("t5_post", ptr, 100, 0, 1'b0, ptr);

        // Reset mid-packet after 3 of 5 bytes
        acc = 0;
        n   = 0;
        while (acc < 3 && n < 20) begin
            @(negedge clk);
            set_src(0, 1'b1, 8'(8'hA0 + acc), 1'b0);
            #1;
            n++;
            if (req_ready[0]) acc++;
        end
        chk("t6_accepts", acc, 3);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_valid", tx_data_valid, 1'b0);
        chk("t6_grant", grant, 3'b000);
        chk("t6_busy", busy, 1'b0);
        chk("t6_ready", req_ready, 3'b000);
        set_src(0, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        set_src(1, 1'b1, 8'h5A, 1'b1);
        @(negedge clk);
        #1 chk("t6_fresh_grant", grant, 3'b010);
        @(negedge clk);
        set_src(1, 1'b0, 8'h00, 1'b0);
        #1;
        chk("t6_fresh_data", tx_data, 8'h5A);
        chk("t6_fresh_valid", tx_data_valid, 1'b1);

        // Randomized traffic, round-robin pointer chained across rounds
        do_reset();
        ptr = 0;
        for (int r = 0; r < 8; r++) begin
            clear_pkts();
            for (int s = 0; s < NR; s++)
                repeat ($urandom_range(3))
                    add_pkt(s, $urandom_range(1, 6), 1'b1);
            run_pkts("rnd", ptr, $urandom_range(40, 100),
                     $urandom_range(0, 30), 1'b0, ptr);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
